// File: rtl/i2c_target_axis.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_axis
// Brief    : I2C target endpoint; bus writes leave on m_axis, bus reads are
//            sourced from s_axis. Open-drain SDA, no clock stretching.
// Revision : 1.0
// ============================================================================
module i2c_target_axis #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_oe_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tuser,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o,
  output logic       stop_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]             w_rx_byte, w_load_byte;

  state_t     r_state;
  logic [7:0] r_shift, r_tx, r_m_tdata;
  logic [2:0] r_bit_cnt;
  logic       r_rw, r_ninth, r_ack_ok, r_first;
  logic       r_sda_oe, r_busy, r_stop, r_m_tuser, r_m_tvalid, r_s_tready;

  assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise  =  w_scl_s & ~r_scl_d;
  assign w_scl_fall  = ~w_scl_s &  r_scl_d;
  assign w_start     =  w_scl_s &  r_scl_d &  r_sda_d & ~w_sda_s;
  assign w_stop      =  w_scl_s &  r_scl_d & ~r_sda_d &  w_sda_s;
  assign w_rx_byte   = {r_shift[6:0], w_sda_s};
  assign w_load_byte = s_axis_tvalid ? s_axis_tdata : 8'hFF;

  // Synchronisers reset to the idle-bus level so reset release never fakes an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_tx       <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_rw       <= 1'b0;
      r_ninth    <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_first    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_stop     <= 1'b0;
      r_m_tdata  <= 8'h00;
      r_m_tuser  <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_s_tready <= 1'b0;
    end else begin
      r_stop     <= 1'b0;
      r_s_tready <= 1'b0;
      if (r_m_tvalid && m_axis_tready) r_m_tvalid <= 1'b0;

      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_stop   <= 1'b1;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_rx_byte[7:1] == ADDR) begin
                r_state <= S_ADDR_ACK;
                r_busy  <= 1'b1;
                r_rw    <= w_rx_byte[0];
                r_ninth <= 1'b0;
                r_first <= 1'b1;
              end else begin
                r_state <= S_WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end
          end

          // First fall drives the ACK, the fall ending the 9th clock moves on
          S_ADDR_ACK: if (w_scl_rise) begin
            r_ninth <= 1'b1;
          end else if (w_scl_fall) begin
            if (!r_ninth) begin
              r_sda_oe <= 1'b1;
            end else if (r_rw) begin
              r_state    <= S_RD_DATA;
              r_tx       <= w_load_byte;
              r_sda_oe   <= ~w_load_byte[7];
              r_s_tready <= s_axis_tvalid;
              r_bit_cnt  <= 3'd0;
            end else begin
              r_state   <= S_WR_DATA;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd0;
            end
          end

          S_WR_DATA: if (w_scl_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (!r_m_tvalid || m_axis_tready) begin
                r_m_tdata  <= w_rx_byte;
                r_m_tuser  <= r_first;
                r_m_tvalid <= 1'b1;
                r_first    <= 1'b0;
                r_ack_ok   <= 1'b1;
              end else begin
                r_ack_ok   <= 1'b0;
              end
              r_state <= S_WR_ACK;
              r_ninth <= 1'b0;
            end
          end

          S_WR_ACK: if (w_scl_rise) begin
            r_ninth <= 1'b1;
          end else if (w_scl_fall) begin
            if (!r_ninth) begin
              r_sda_oe <= r_ack_ok;
            end else begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_state   <= r_ack_ok ? S_WR_DATA : S_WAIT_STOP;
            end
          end

          S_RD_DATA: if (w_scl_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_RD_ACK;
              r_ninth  <= 1'b0;
            end else begin
              r_tx     <= {r_tx[6:0], 1'b0};
              r_sda_oe <= ~r_tx[6];
            end
          end

          S_RD_ACK: if (w_scl_rise) begin
            if (w_sda_s) r_state <= S_WAIT_STOP;
            else         r_ninth <= 1'b1;
          end else if (w_scl_fall && r_ninth) begin
            r_state    <= S_RD_DATA;
            r_tx       <= w_load_byte;
            r_sda_oe   <= ~w_load_byte[7];
            r_s_tready <= s_axis_tvalid;
            r_bit_cnt  <= 3'd0;
          end

          default: ;
        endcase
      end
    end
  end

  assign i2c_sda_oe_o  = r_sda_oe;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign s_axis_tready = r_s_tready;
  assign busy_o        = r_busy;
  assign stop_o        = r_stop;

endmodule
`default_nettype wire
